// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two requesters sharing a single-port RAM, with bounded
// locked bursts, registered RAM drive and tagged read-data return.
module ram_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 64,
    parameter int MAX_BURST = 8,
    parameter int RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          rq0_valid,
    output logic          rq0_ready,
    input  logic          rq0_wen,
    input  logic          rq0_lock,
    input  logic [AW-1:0] rq0_addr,
    input  logic [DW-1:0] rq0_wdata,

    input  logic          rq1_valid,
    output logic          rq1_ready,
    input  logic          rq1_wen,
    input  logic          rq1_lock,
    input  logic [AW-1:0] rq1_addr,
    input  logic [DW-1:0] rq1_wdata,

    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_rdata,

    output logic          ram_cen,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [8:0] MAX_B = 9'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          rr_ptr, rr_ptr_nxt;
    logic [7:0]    beat_cnt, beat_cnt_nxt;

    logic          gnt0, gnt1;
    logic          acc, acc_id;
    logic          sel_wen, sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          last_beat;

    logic [RD_LAT:0] rd_vld_p;
    logic [RD_LAT:0] rd_id_p;

    // Grant depends only on state, rr_ptr and the valids, never on the other ready.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            IDLE: begin
                if (rq0_valid && rq1_valid) begin
                    gnt0 = ~rr_ptr;
                    gnt1 = rr_ptr;
                end else begin
                    gnt0 = rq0_valid;
                    gnt1 = rq1_valid;
                end
            end
            OWN0:    gnt0 = rq0_valid;
            OWN1:    gnt1 = rq1_valid;
            default: ;
        endcase
    end

    assign rq0_ready = gnt0 & reset_n;
    assign rq1_ready = gnt1 & reset_n;
    assign acc       = rq0_ready | rq1_ready;
    assign acc_id    = rq1_ready;

    assign sel_wen   = acc_id ? rq1_wen   : rq0_wen;
    assign sel_lock  = acc_id ? rq1_lock  : rq0_lock;
    assign sel_addr  = acc_id ? rq1_addr  : rq0_addr;
    assign sel_wdata = acc_id ? rq1_wdata : rq0_wdata;

    assign last_beat = ({1'b0, beat_cnt} + 9'd1) >= MAX_B;

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (sel_lock) begin
                        state_nxt    = acc_id ? OWN1 : OWN0;
                        beat_cnt_nxt = 8'd1;
                    end else begin
                        rr_ptr_nxt = ~acc_id;
                    end
                end
            end
            OWN0, OWN1: begin
                // Owner idling, unlocking or hitting the burst limit all hand back to IDLE.
                if (!acc || !sel_lock || last_beat) begin
                    state_nxt    = IDLE;
                    rr_ptr_nxt   = (state == OWN0);
                    beat_cnt_nxt = 8'd0;
                end else begin
                    beat_cnt_nxt = beat_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            beat_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // p0: accepted beat registered onto the RAM pins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_cen  <= 1'b0;
            ram_wen  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_cen <= acc;
            ram_wen <= acc & sel_wen;
            if (acc) begin
                ram_addr <= sel_addr;
                ram_din  <= sel_wdata;
            end
        end
    end

    // p0..pRD_LAT: read tag follows the access until ram_dout is valid
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_vld_p <= '0;
            rd_id_p  <= '0;
        end else begin
            rd_vld_p <= {rd_vld_p[RD_LAT-1:0], acc & ~sel_wen};
            rd_id_p  <= {rd_id_p[RD_LAT-1:0], acc_id};
        end
    end

    assign rsp0_valid = rd_vld_p[RD_LAT] & ~rd_id_p[RD_LAT];
    assign rsp1_valid = rd_vld_p[RD_LAT] &  rd_id_p[RD_LAT];
    assign rsp_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed beats, RAM behavioural model, and a
// monitor that checks returned read data, tag and latency against queued expectations.
module tb_ram_arbiter;

    localparam int AW = 8, DW = 64, MAX_BURST = 8, RD_LAT = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rq0_valid, rq0_ready, rq0_wen, rq0_lock;
    logic [AW-1:0] rq0_addr;
    logic [DW-1:0] rq0_wdata;
    logic          rq1_valid, rq1_ready, rq1_wen, rq1_lock;
    logic [AW-1:0] rq1_addr;
    logic [DW-1:0] rq1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_rdata;
    logic          ram_cen, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_wen(rq0_wen), .rq0_lock(rq0_lock),
        .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_wen(rq1_wen), .rq1_lock(rq1_lock),
        .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM macro model: samples on the rising edge, data out RD_LAT cycles later.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_cen && ram_wen) mem[ram_addr] <= ram_din;
        rd_pipe[0] <= (ram_cen && !ram_wen) ? mem[ram_addr] : '0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_dout = rd_pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    typedef struct packed {
        logic          v;
        logic          lock;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            cyc;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] shadow [256];

    logic          exp_cen = 1'b0, exp_wen = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;

    function automatic beat_t I();
        return '0;
    endfunction
    function automatic beat_t W(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        return '{v: 1'b1, lock: l, wen: 1'b1, addr: a, data: d};
    endfunction
    function automatic beat_t R(input logic [AW-1:0] a, input logic l);
        return '{v: 1'b1, lock: l, wen: 1'b0, addr: a, data: '0};
    endfunction

    // One cycle: drive, check readies and RAM pins at negedge, book the expected outcome.
    task automatic step(input logic rn, input beat_t b0, input beat_t b1,
                        input logic er0, input logic er1, input string nm);
        beat_t b;
        reset_n   = rn;
        rq0_valid = b0.v; rq0_lock = b0.lock; rq0_wen = b0.wen; rq0_addr = b0.addr; rq0_wdata = b0.data;
        rq1_valid = b1.v; rq1_lock = b1.lock; rq1_wen = b1.wen; rq1_addr = b1.addr; rq1_wdata = b1.data;
        @(negedge clk);
        chk({nm, " rdy0"}, 64'(rq0_ready), 64'(er0));
        chk({nm, " rdy1"}, 64'(rq1_ready), 64'(er1));
        chk({nm, " cen"},  64'(ram_cen),   64'(exp_cen));
        chk({nm, " wen"},  64'(ram_wen),   64'(exp_wen));
        chk({nm, " addr"}, 64'(ram_addr),  64'(exp_addr));
        chk({nm, " din"},  ram_din,        exp_din);
        if (!rn) begin
            chk({nm, " rsp"}, 64'({rsp0_valid, rsp1_valid}), 64'd0);
            exp_cen = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_din = '0;
        end else if (er0 || er1) begin
            b = er1 ? b1 : b0;
            exp_cen = 1'b1; exp_wen = b.wen; exp_addr = b.addr; exp_din = b.data;
            if (b.wen) shadow[b.addr] = b.data;
            else exp_q.push_back('{id: er1, data: shadow[b.addr], cyc: cyc + 1 + RD_LAT});
        end else begin
            exp_cen = 1'b0; exp_wen = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented response must match the head of the scoreboard.
    always @(negedge clk) begin
        rsp_t e;
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_onehot", 64'(rsp0_valid & rsp1_valid), 64'd0);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'({rsp0_valid, rsp1_valid}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id",   64'(rsp1_valid), 64'(e.id));
                chk("rsp_data", rsp_rdata,       e.data);
                chk("rsp_cyc",  64'(cyc),        64'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam logic [DW-1:0] D1 = 64'h1111_1111_1111_1111;
    localparam logic [DW-1:0] D2 = 64'h2222_2222_2222_2222;
    localparam logic [DW-1:0] D3 = 64'h3333_3333_3333_3333;
    localparam logic [DW-1:0] D4 = 64'h4444_4444_4444_4444;
    localparam logic [DW-1:0] DA = 64'hAAAA_AAAA_AAAA_AAAA;

    initial begin
        int k;
        logic e0, e1;
        reset_n = 1'b0;
        rq0_valid = 0; rq0_lock = 0; rq0_wen = 0; rq0_addr = '0; rq0_wdata = '0;
        rq1_valid = 0; rq1_lock = 0; rq1_wen = 0; rq1_addr = '0; rq1_wdata = '0;
        @(posedge clk);
        #1;

        // Reset held with both requesters asking
        repeat (3) step(1'b0, R(8'h00, 1'b0), R(8'h04, 1'b0), 1'b0, 1'b0, "reset");
        step(1'b1, I(), I(), 1'b0, 1'b0, "idle");

        // Single requester, back-to-back writes then reads
        step(1'b1, W(8'h00, D1, 1'b0), I(), 1'b1, 1'b0, "single_w0");
        step(1'b1, W(8'h04, D2, 1'b0), I(), 1'b1, 1'b0, "single_w1");
        step(1'b1, W(8'h08, D3, 1'b0), I(), 1'b1, 1'b0, "single_w2");
        step(1'b1, R(8'h00, 1'b0),     I(), 1'b1, 1'b0, "single_r0");
        step(1'b1, R(8'h04, 1'b0),     I(), 1'b1, 1'b0, "single_r1");
        step(1'b1, R(8'h08, 1'b0),     I(), 1'b1, 1'b0, "single_r2");
        repeat (3) step(1'b1, I(), I(), 1'b0, 1'b0, "drain");

        // rq1 alone: rr_ptr was pointing at 1, now hands the next tie to 0
        step(1'b1, I(), W(8'h10, DA, 1'b0), 1'b0, 1'b1, "rq1_w");

        // Contention, no lock: alternate 0,1,0,1
        for (int i = 0; i < 4; i++)
            step(1'b1, R(8'h00, 1'b0), R(8'h10, 1'b0), (i % 2) == 0, (i % 2) == 1, "contend");
        repeat (2) step(1'b1, I(), I(), 1'b0, 1'b0, "drain");

        // Locked burst of 12 from rq0 against a waiting rq1
        k = 0;
        for (int s = 1; s <= 15; s++) begin
            e0 = (s <= 8) || (s >= 10 && s <= 13);
            e1 = (s == 9) || (s == 15);
            step(1'b1, (k < 12) ? W(8'h20 + 8'(k), 64'(k), 1'b1) : I(), R(8'h10, 1'b0), e0, e1, "burst");
            if (e0) k++;
        end
        repeat (2) step(1'b1, I(), I(), 1'b0, 1'b0, "drain");

        // Owner 1 drops valid: release, then rq0 wins the tie
        step(1'b1, I(),            W(8'h30, D4, 1'b1), 1'b0, 1'b1, "own1_lock");
        step(1'b1, R(8'h00, 1'b0), I(),                1'b0, 1'b0, "own1_drop");
        step(1'b1, R(8'h00, 1'b0), R(8'h30, 1'b0),     1'b1, 1'b0, "tie_after_rel");
        step(1'b1, I(),            R(8'h30, 1'b0),     1'b0, 1'b1, "rq1_after");
        repeat (2) step(1'b1, I(), I(), 1'b0, 1'b0, "drain");

        // Reset lands while a read is in flight: it must never be answered
        step(1'b1, R(8'h8F, 1'b0), I(), 1'b1, 1'b0, "inflight_rd");
        void'(exp_q.pop_back());
        step(1'b0, I(), I(), 1'b0, 1'b0, "mid_reset");
        repeat (4) step(1'b1, I(), I(), 1'b0, 1'b0, "post_reset");

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        chk("pending_rsp", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
